// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the I-cache (read-only)
// and the D-cache (read/write) controllers, one BURST_LEN-beat line transfer at a time.
module mem_port_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = $clog2(BURST_LEN)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [BEAT_W-1:0] I_BEAT,
  output logic              I_DONE,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [BEAT_W-1:0] D_BEAT,
  output logic              D_DONE,
  output logic [31:0]       RDATA,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DIN,
  input  logic [31:0]       MEM_DOUT,
  input  logic              MEM_VALID
);

  // state  | meaning
  // S_IDLE | no owner; requests sampled, round-robin on a tie
  // S_BUSY | burst in flight, counting MEM_VALID beats
  // S_DONE | one-cycle completion pulse to the owner
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN * 4 - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_owner_d;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [BEAT_W-1:0]   r_count;
  logic                r_last_d;

  logic                w_any_req;
  logic                w_grant_d;
  logic                w_last_beat;
  logic                w_gnt;
  logic                w_rvalid;
  logic                w_done;
  logic [BEAT_W-1:0]   w_beat;

  assign w_any_req   = I_REQ | D_REQ;
  // On a tie the port that did not own the previous burst wins.
  assign w_grant_d   = D_REQ & (~I_REQ | ~r_last_d);
  assign w_last_beat = MEM_VALID && (r_count == BEAT_W'(BURST_LEN - 1));
  assign RDATA       = MEM_DOUT;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)   w_next = S_BUSY;
      S_BUSY:  if (w_last_beat) w_next = S_DONE;
      S_DONE:                   w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_count   <= '0;
      r_last_d  <= 1'b1;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_owner_d <= w_grant_d;
        r_we      <= w_grant_d & D_WE;
        r_addr    <= (w_grant_d ? D_ADDR : I_ADDR) & LINE_MASK;
      end
      if (r_state == S_BUSY && MEM_VALID)
        r_count <= w_last_beat ? '0 : r_count + BEAT_W'(1);
      if (r_state == S_DONE)
        r_last_d <= r_owner_d;
    end
  end

  always_comb begin
    w_gnt    = 1'b0;
    w_rvalid = 1'b0;
    w_done   = 1'b0;
    w_beat   = '0;
    MEM_RE   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    MEM_DIN  = '0;
    case (r_state)
      S_BUSY: begin
        w_gnt    = 1'b1;
        MEM_RE   = ~r_we;
        MEM_WE   = r_we;
        MEM_ADDR = r_addr;
        MEM_DIN  = (r_owner_d && r_we) ? D_WDATA : 32'd0;
        w_rvalid = MEM_VALID & ~r_we;
        w_beat   = r_count;
      end
      S_DONE: begin
        w_gnt    = 1'b1;
        w_done   = 1'b1;
        MEM_ADDR = r_addr;
      end
      default: ;
    endcase
    I_GNT    = w_gnt & ~r_owner_d;
    I_RVALID = w_rvalid & ~r_owner_d;
    I_DONE   = w_done & ~r_owner_d;
    I_BEAT   = r_owner_d ? '0 : w_beat;
    D_GNT    = w_gnt & r_owner_d;
    D_RVALID = w_rvalid & r_owner_d;
    D_DONE   = w_done & r_owner_d;
    D_BEAT   = r_owner_d ? w_beat : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model answers bursts, a reference
// model queues the expected event stream, and a negedge monitor compares it.
module tb_mem_port_arbiter;
  localparam int BURST_LEN = 4;
  localparam int ADDR_W    = 32;
  localparam int BEAT_W    = 2;
  localparam int MEM_WORDS = 1024;
  localparam int K_START = 0, K_BEAT = 1, K_DONE = 2;

  logic              CLK, RST;
  logic              I_REQ, I_GNT, I_RVALID, I_DONE;
  logic [ADDR_W-1:0] I_ADDR;
  logic [BEAT_W-1:0] I_BEAT, D_BEAT;
  logic              D_REQ, D_WE, D_GNT, D_RVALID, D_DONE;
  logic [ADDR_W-1:0] D_ADDR, MEM_ADDR;
  logic [31:0]       D_WDATA, RDATA, MEM_DIN, MEM_DOUT, wbase;
  logic              MEM_RE, MEM_WE, MEM_VALID;

  mem_port_arbiter #(.BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_BEAT(I_BEAT), .I_DONE(I_DONE),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(D_GNT), .D_RVALID(D_RVALID),
    .D_BEAT(D_BEAT), .D_DONE(D_DONE), .RDATA(RDATA), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT), .MEM_VALID(MEM_VALID));

  // The D-cache supplies the writeback word for whatever beat the arbiter is on.
  assign D_WDATA = wbase + 32'(D_BEAT);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          kind;
    int          port;
    int          beat;
    logic [31:0] data;
    logic [31:0] addr;
  } ev_t;

  ev_t         exp_q[$];
  int          gap_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem[MEM_WORDS];
  logic [31:0] ref_mem[MEM_WORDS];
  int          ref_last = 1;
  int          mem_delay = 3;
  bit          gap_en = 0;
  bit          stray_req = 0;
  int          cyc = 0;
  int          last_done_cyc = -100;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(MEM_WORDS - 1));
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a whole line transfer becomes START, beats, DONE in grant order.
  task automatic push_txn(input int port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wb, input int nbeats, input bit with_done);
    ev_t         e;
    logic [31:0] line;
    line = addr & ~32'(BURST_LEN * 4 - 1);
    e = '{kind: K_START, port: port, beat: 0, data: 32'(we), addr: line};
    exp_q.push_back(e);
    for (int b = 0; b < nbeats; b++) begin
      e = '{kind: K_BEAT, port: port, beat: b, data: 32'd0, addr: 32'd0};
      if (we) begin
        e.data = wb + 32'(b);
        ref_mem[widx(line + 32'(4 * b))] = wb + 32'(b);
      end else begin
        e.data = ref_mem[widx(line + 32'(4 * b))];
      end
      exp_q.push_back(e);
    end
    if (with_done) begin
      e = '{kind: K_DONE, port: port, beat: 0, data: 32'd0, addr: 32'd0};
      exp_q.push_back(e);
      ref_last = port;
    end
  endtask

  // Memory model: first beat after mem_delay busy cycles, optional random gaps.
  int mm_cnt = 0, mm_beat = 0;
  initial begin
    MEM_VALID = 1'b0;
    MEM_DOUT  = 32'd0;
    forever begin
      @(posedge CLK);
      #1;
      MEM_VALID = 1'b0;
      if (stray_req) begin
        MEM_VALID = 1'b1;
        MEM_DOUT  = $urandom;
        stray_req = 0;
      end else if (MEM_RE || MEM_WE) begin
        mm_cnt++;
        if (mm_cnt >= mem_delay && mm_beat < BURST_LEN && !(gap_en && $urandom_range(0, 3) == 0)) begin
          MEM_VALID = 1'b1;
          if (MEM_RE) MEM_DOUT = mem[widx(MEM_ADDR + 32'(4 * mm_beat))];
          else        mem[widx(MEM_ADDR + 32'(4 * mm_beat))] = MEM_DIN;
          mm_beat++;
        end
      end else begin
        mm_cnt  = 0;
        mm_beat = 0;
      end
    end
  end

  task automatic observe(input int kind, input int port, input int beat,
                         input logic [31:0] data, input logic [31:0] addr);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d port=%0d beat=%0d, expected no event (cycle %0d)",
               kind, port, beat, cyc);
    end else begin
      e = exp_q.pop_front();
      chk32("event_kind", 32'(kind), 32'(e.kind));
      if (kind == e.kind) begin
        chk32("event_port", 32'(port), 32'(e.port));
        if (kind == K_BEAT) begin
          chk32("beat_index", 32'(beat), 32'(e.beat));
          chk32("beat_data", data, e.data);
        end
        if (kind == K_START) begin
          chk32("start_we", data, e.data);
          chk32("start_addr", addr, e.addr);
        end
      end
    end
  endtask

  bit prev_act = 0, prev_ig = 0, prev_dg = 0;
  initial begin
    forever begin
      logic [9:0] v;
      @(negedge CLK);
      cyc++;
      if ((MEM_RE || MEM_WE) && !prev_act)
        observe(K_START, D_GNT ? 1 : 0, 0, 32'(MEM_WE), MEM_ADDR);
      if (I_RVALID) observe(K_BEAT, 0, int'(I_BEAT), RDATA, 32'd0);
      if (D_RVALID) observe(K_BEAT, 1, int'(D_BEAT), RDATA, 32'd0);
      if (D_GNT && MEM_WE && MEM_VALID) observe(K_BEAT, 1, int'(D_BEAT), MEM_DIN, 32'd0);
      if (I_DONE) observe(K_DONE, 0, 0, 32'd0, 32'd0);
      if (D_DONE) observe(K_DONE, 1, 0, 32'd0, 32'd0);
      v[0] = I_GNT & D_GNT;
      v[1] = I_RVALID != (I_GNT & MEM_RE & MEM_VALID);
      v[2] = D_RVALID != (D_GNT & MEM_RE & MEM_VALID);
      v[3] = I_GNT & MEM_WE;
      v[4] = !I_GNT && (I_BEAT != 0 || I_DONE);
      v[5] = !D_GNT && (D_BEAT != 0 || D_DONE);
      v[6] = (I_DONE | D_DONE) & (MEM_RE | MEM_WE);
      v[7] = (MEM_DIN != 0) && !(D_GNT && MEM_WE);
      v[8] = MEM_RE & MEM_WE;
      v[9] = (MEM_RE | MEM_WE) & !(I_GNT | D_GNT);
      chk32("port_invariants", 32'(v), 32'd0);
      if ((I_GNT && !prev_ig) || (D_GNT && !prev_dg)) gap_q.push_back(cyc - last_done_cyc);
      if (I_DONE || D_DONE) last_done_cyc = cyc;
      prev_act = MEM_RE | MEM_WE;
      prev_ig  = I_GNT;
      prev_dg  = D_GNT;
    end
  end

  task automatic run_i(input logic [31:0] a);
    I_ADDR = a;
    I_REQ  = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (I_DONE) begin
        I_REQ = 1'b0;
        return;
      end
    end
    I_REQ = 1'b0;
    chk32("i_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_d(input bit we, input logic [31:0] a, input logic [31:0] wb);
    D_WE   = we;
    D_ADDR = a;
    wbase  = wb;
    D_REQ  = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (D_DONE) begin
        D_REQ = 1'b0;
        return;
      end
    end
    D_REQ = 1'b0;
    chk32("d_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    chk32({name, "_ctrl"}, 32'({I_GNT, I_RVALID, I_DONE, D_GNT, D_RVALID, D_DONE, MEM_RE, MEM_WE, I_BEAT, D_BEAT}), 32'd0);
    chk32({name, "_addr"}, MEM_ADDR, 32'd0);
    chk32({name, "_din"}, MEM_DIN, 32'd0);
  endtask

  task automatic do_tie(input logic [31:0] ia, input bit dwe, input logic [31:0] da, input logic [31:0] wb);
    gap_q.delete();
    if (ref_last == 1) begin
      push_txn(0, 0, ia, 0, BURST_LEN, 1);
      push_txn(1, dwe, da, wb, BURST_LEN, 1);
    end else begin
      push_txn(1, dwe, da, wb, BURST_LEN, 1);
      push_txn(0, 0, ia, 0, BURST_LEN, 1);
    end
    fork
      run_i(ia);
      run_d(dwe, da, wb);
    join
  endtask

  initial begin
    int nb;
    int bad;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = 32'h1000_0000 ^ (32'(i) * 32'h0000_9E37);
      ref_mem[i] = mem[i];
    end
    RST = 1'b1; I_REQ = 1'b0; I_ADDR = '0; D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; wbase = '0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Tie after reset: I first, then I re-requests while D waits, so D wins the next tie.
    gap_q.delete();
    push_txn(0, 0, 32'h0000_0100, 0, BURST_LEN, 1);
    push_txn(1, 0, 32'h0000_0200, 0, BURST_LEN, 1);
    push_txn(0, 0, 32'h0000_0110, 0, BURST_LEN, 1);
    fork
      begin run_i(32'h0000_0100); run_i(32'h0000_0110); end
      run_d(1'b0, 32'h0000_0200, 32'd0);
    join
    chk32("tie_gap_count", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      chk32("tie_handoff_d", 32'(gap_q[1]), 32'd2);
      chk32("tie_handoff_i", 32'(gap_q[2]), 32'd2);
    end
    do_tie(32'h0000_0300, 1'b1, 32'h0000_0340, 32'h0000_0055);
    if (gap_q.size() == 2) chk32("tie2_handoff", 32'(gap_q[1]), 32'd2);
    else chk32("tie2_gap_count", 32'(gap_q.size()), 32'd2);

    // I-cache line read with a slow memory.
    mem_delay = 10;
    push_txn(0, 0, 32'h0000_1234, 0, BURST_LEN, 1);
    run_i(32'h0000_1234);

    // D-cache writeback of 0xA0..0xA3.
    mem_delay = 3;
    push_txn(1, 1, 32'h0000_0040, 32'h0000_00A0, BURST_LEN, 1);
    run_d(1'b1, 32'h0000_0040, 32'h0000_00A0);
    for (int b = 0; b < 4; b++) chk32("writeback_word", mem[16 + b], 32'h0000_00A0 + 32'(b));

    // D request arrives mid I burst and waits for the I completion.
    mem_delay = 5;
    gap_q.delete();
    push_txn(0, 0, 32'h0000_0500, 0, BURST_LEN, 1);
    push_txn(1, 0, 32'h0000_0600, 0, BURST_LEN, 1);
    fork
      run_i(32'h0000_0500);
      begin repeat (4) @(negedge CLK); run_d(1'b0, 32'h0000_0600, 32'd0); end
    join
    if (gap_q.size() == 2) chk32("wait_handoff", 32'(gap_q[1]), 32'd2);
    else chk32("wait_gap_count", 32'(gap_q.size()), 32'd2);

    // Stray MEM_VALID while idle must not disturb the next burst.
    mem_delay = 2;
    @(negedge CLK);
    stray_req = 1;
    repeat (3) @(negedge CLK);
    push_txn(1, 0, 32'h0000_0080, 0, BURST_LEN, 1);
    run_d(1'b0, 32'h0000_0080, 32'd0);

    // Reset after the second beat of an I read abandons it without a DONE.
    mem_delay = 3;
    push_txn(0, 0, 32'h0000_0700, 0, 2, 0);
    I_ADDR = 32'h0000_0700;
    I_REQ  = 1'b1;
    nb = 0;
    for (int k = 0; k < 100 && nb < 2; k++) begin
      @(negedge CLK);
      if (I_RVALID) nb++;
    end
    chk32("abort_beats_seen", 32'(nb), 32'd2);
    RST   = 1'b1;
    I_REQ = 1'b0;
    @(negedge CLK);
    check_idle_outputs("abort");
    RST = 1'b0;
    ref_last = 1;
    @(negedge CLK);
    push_txn(1, 0, 32'h0000_0780, 0, BURST_LEN, 1);
    run_d(1'b0, 32'h0000_0780, 32'd0);

    // Randomized traffic.
    gap_en = 1;
    for (int n = 0; n < 40; n++) begin
      int          mode;
      logic [31:0] ia, da, wb;
      bit          dwe;
      mem_delay = int'($urandom_range(1, 6));
      mode = int'($urandom_range(0, 3));
      ia   = $urandom & 32'h0000_0FFF;
      da   = $urandom & 32'h0000_0FFF;
      wb   = $urandom;
      dwe  = 1'($urandom_range(0, 1));
      case (mode)
        0: begin push_txn(0, 0, ia, 0, BURST_LEN, 1); run_i(ia); end
        1: begin push_txn(1, 0, da, 0, BURST_LEN, 1); run_d(1'b0, da, 32'd0); end
        2: begin push_txn(1, 1, da, wb, BURST_LEN, 1); run_d(1'b1, da, wb); end
        default: do_tie(ia, dwe, da, wb);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk32("memory_image_diffs", 32'(bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
